// File: rtl/vga_pkg.sv
// Shared definitions for the VGA render pipeline: game mode encoding and
// the 8-bit RRR_GGG_BB palette used by the colour stage.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_INIT  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_PAUSE = 2'b10,
        MODE_OVER  = 2'b11
    } gamemode_e;

    localparam logic [7:0] RGB_BG_INIT  = 8'b110_110_11;
    localparam logic [7:0] RGB_BG_RUN   = 8'b000_111_00;
    localparam logic [7:0] RGB_BG_PAUSE = 8'b111_111_00;
    localparam logic [7:0] RGB_BG_OVER  = 8'b111_000_00;
    localparam logic [7:0] RGB_COLLIDE  = 8'b111_111_11;
    localparam logic [7:0] RGB_PLAYER   = 8'b000_000_11;
    localparam logic [7:0] RGB_OBS      = 8'b111_011_00;
    localparam logic [7:0] RGB_OBS_OVER = 8'b011_000_00;

    // Background colour for a given game mode.
    function automatic logic [7:0] bg_colour(input gamemode_e mode);
        case (mode)
            MODE_INIT:  return RGB_BG_INIT;
            MODE_RUN:   return RGB_BG_RUN;
            MODE_PAUSE: return RGB_BG_PAUSE;
            default:    return RGB_BG_OVER;
        endcase
    endfunction

endpackage

// File: rtl/vga_obs_hit.sv
// Single obstacle slot hit test. A slot with left==right and top==bottom is
// an empty slot; otherwise the rectangle is half-open [left,right)x[top,bottom).
module vga_obs_hit #(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic [XW-1:0] pix_x_i,
    input  logic [YW-1:0] pix_y_i,
    input  logic [XW-1:0] left_i,
    input  logic [XW-1:0] right_i,
    input  logic [YW-1:0] top_i,
    input  logic [YW-1:0] bottom_i,
    output logic          hit_o
);

    logic disabled;

    assign disabled = (left_i == right_i) && (top_i == bottom_i);

    // Inverted or empty ranges fall out of the compares naturally.
    assign hit_o = !disabled
                && (pix_x_i >= left_i) && (pix_x_i < right_i)
                && (pix_y_i >= top_i)  && (pix_y_i < bottom_i);

endmodule

// File: rtl/vga_render_pipe.sv
// Two-stage pixel colour pipeline. Game state is sampled into shadow
// registers on frame_start so a frame is always rendered from one snapshot.
// Stage 1 resolves object hits, stage 2 resolves colour priority.
module vga_render_pipe
    import vga_pkg::*;
#(
    parameter int N_OBS        = 10,
    parameter int XW           = 10,
    parameter int YW           = 9,
    parameter int PLAYER_X     = 160,
    parameter int PLAYER_SIZE  = 40,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [XW-1:0]         pix_x,
    input  logic [YW-1:0]         pix_y,
    input  logic                  pix_valid,
    input  logic                  frame_start,
    input  logic [1:0]            gamemode,
    input  logic [YW-1:0]         player_y,
    input  logic [N_OBS*2*XW-1:0] obstacle_x,
    input  logic [N_OBS*2*YW-1:0] obstacle_y,
    output logic [7:0]            rgb,
    output logic                  rgb_valid
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [XW:0] PX_LO = (XW+1)'(PLAYER_X);
    localparam logic [XW:0] PX_HI = (XW+1)'(PLAYER_X + PLAYER_SIZE);

    // Shadow state; armed_q keeps the player hidden until the first snapshot.
    gamemode_e             mode_q;
    logic [YW-1:0]         player_y_q;
    logic [N_OBS*2*XW-1:0] obs_x_q;
    logic [N_OBS*2*YW-1:0] obs_y_q;
    logic                  armed_q;

    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_q, blink_d;

    logic          player_hit_d, obs_hit_d;
    logic [N_OBS-1:0] obs_hits;
    logic [YW:0]   py_hi;

    logic          valid1_q, player1_q, obs1_q, coll1_q, blink1_q;
    gamemode_e     mode1_q;
    logic          show_player;

    logic [7:0]    rgb_d, rgb_q;
    logic          rgb_valid_q;

    // Snapshot game state at the start of vertical blanking.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_INIT;
            player_y_q <= '0;
            obs_x_q    <= '0;
            obs_y_q    <= '0;
            armed_q    <= 1'b0;
        end else if (frame_start) begin
            mode_q     <= gamemode_e'(gamemode);
            player_y_q <= player_y;
            obs_x_q    <= obstacle_x;
            obs_y_q    <= obstacle_y;
            armed_q    <= 1'b1;
        end
    end

    // Blink counter next state: wrap at BLINK_FRAMES-1 and flip the phase.
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (frame_start) begin
            if (frame_cnt_q == CW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Blink counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

    // One comparator per obstacle slot, OR-reduced into a single hit.
    for (genvar i = 0; i < N_OBS; i++) begin : g_obs
        vga_obs_hit #(.XW(XW), .YW(YW)) u_obs_hit (
            .pix_x_i  (pix_x),
            .pix_y_i  (pix_y),
            .left_i   (obs_x_q[i*2*XW +: XW]),
            .right_i  (obs_x_q[i*2*XW+XW +: XW]),
            .top_i    (obs_y_q[i*2*YW +: YW]),
            .bottom_i (obs_y_q[i*2*YW+YW +: YW]),
            .hit_o    (obs_hits[i])
        );
    end

    assign obs_hit_d = |obs_hits;

    // Player box compare in one extra bit so a low player never wraps to the top.
    assign py_hi        = {1'b0, player_y_q} + (YW+1)'(PLAYER_SIZE);
    assign player_hit_d = armed_q
                       && ({1'b0, pix_x} >= PX_LO) && ({1'b0, pix_x} < PX_HI)
                       && ({1'b0, pix_y} >= {1'b0, player_y_q})
                       && ({1'b0, pix_y} < py_hi);

    // Stage 1: register hit flags together with the mode/phase they apply to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_q  <= 1'b0;
            player1_q <= 1'b0;
            obs1_q    <= 1'b0;
            coll1_q   <= 1'b0;
            mode1_q   <= MODE_INIT;
            blink1_q  <= 1'b0;
        end else begin
            valid1_q  <= pix_valid;
            player1_q <= player_hit_d;
            obs1_q    <= obs_hit_d;
            coll1_q   <= player_hit_d && obs_hit_d;
            mode1_q   <= mode_q;
            blink1_q  <= blink_q;
        end
    end

    assign show_player = (mode1_q != MODE_PAUSE) || blink1_q;

    // Colour priority: collision > player > obstacle > background; black when idle.
    always_comb begin
        rgb_d = '0;
        if (valid1_q) begin
            if (coll1_q && show_player)
                rgb_d = RGB_COLLIDE;
            else if (player1_q && show_player)
                rgb_d = RGB_PLAYER;
            else if (obs1_q)
                rgb_d = (mode1_q == MODE_OVER) ? RGB_OBS_OVER : RGB_OBS;
            else
                rgb_d = bg_colour(mode1_q);
        end
    end

    // Stage 2: registered colour output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
        end else begin
            rgb_q       <= rgb_d;
            rgb_valid_q <= valid1_q;
        end
    end

    assign rgb       = rgb_q;
    assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_vga_render_pipe.sv
// Directed bench for vga_render_pipe with hand-computed colours.
module tb_vga_render_pipe;

    localparam int N_OBS = 10;
    localparam int XW    = 10;
    localparam int YW    = 9;
    localparam int BF    = 2;

    localparam logic [7:0] C_INIT     = 8'hDB;  // 110_110_11
    localparam logic [7:0] C_RUN      = 8'h1C;  // 000_111_00
    localparam logic [7:0] C_PAUSE    = 8'hFC;  // 111_111_00
    localparam logic [7:0] C_OVER     = 8'hE0;  // 111_000_00
    localparam logic [7:0] C_COLL     = 8'hFF;  // 111_111_11
    localparam logic [7:0] C_PLAYER   = 8'h03;  // 000_000_11
    localparam logic [7:0] C_OBS      = 8'hEC;  // 111_011_00
    localparam logic [7:0] C_OBS_OVER = 8'h60;  // 011_000_00

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [XW-1:0]         pix_x;
    logic [YW-1:0]         pix_y;
    logic                  pix_valid;
    logic                  frame_start;
    logic [1:0]            gamemode;
    logic [YW-1:0]         player_y;
    logic [N_OBS*2*XW-1:0] obstacle_x;
    logic [N_OBS*2*YW-1:0] obstacle_y;
    logic [7:0]            rgb;
    logic                  rgb_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench-side blink model.
    int   m_cnt   = 0;
    logic m_blink = 1'b0;

    always #5 clk = ~clk;

    vga_render_pipe #(
        .N_OBS(N_OBS), .XW(XW), .YW(YW),
        .PLAYER_X(160), .PLAYER_SIZE(40), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .frame_start(frame_start), .gamemode(gamemode),
        .player_y(player_y), .obstacle_x(obstacle_x), .obstacle_y(obstacle_y),
        .rgb(rgb), .rgb_valid(rgb_valid)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic set_slot(input int i, input int l, input int r, input int t, input int b);
        obstacle_x[i*2*XW +: XW]    = XW'(l);
        obstacle_x[i*2*XW+XW +: XW] = XW'(r);
        obstacle_y[i*2*YW +: YW]    = YW'(t);
        obstacle_y[i*2*YW+YW +: YW] = YW'(b);
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        if (m_cnt == BF - 1) begin
            m_cnt   = 0;
            m_blink = ~m_blink;
        end else begin
            m_cnt++;
        end
    endtask

    // One isolated pixel: no output after one cycle, valid colour after two.
    task automatic send_pixel(input int x, input int y, input logic [7:0] exp, input string tag);
        @(negedge clk);
        pix_x     = XW'(x);
        pix_y     = YW'(y);
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        check({tag, "_lat1"}, {7'd0, rgb_valid}, 8'd0);
        @(negedge clk);
        check({tag, "_vld"}, {7'd0, rgb_valid}, 8'd1);
        check(tag, rgb, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        gamemode    = 2'b00;
        player_y    = '0;
        obstacle_x  = '0;
        obstacle_y  = '0;

        repeat (3) @(negedge clk);
        check("reset_rgb", rgb, 8'd0);
        check("reset_vld", {7'd0, rgb_valid}, 8'd0);
        rst_n = 1'b1;

        // Before any snapshot: init background, player (y 0..39) not drawn.
        send_pixel(170, 10, C_INIT, "pre_frame_player");

        // Single obstacle in run mode.
        gamemode = 2'b01;
        player_y = 9'd400;
        set_slot(0, 300, 340, 100, 150);
        pulse_frame();
        send_pixel(320, 120, C_OBS, "obs_run");
        send_pixel(10, 10, C_RUN, "bg_run");

        // Player overlapping an obstacle, with box edges.
        player_y = 9'd100;
        set_slot(0, 150, 200, 110, 130);
        pulse_frame();
        send_pixel(170, 115, C_COLL,   "collide");
        send_pixel(170, 135, C_PLAYER, "player_only");
        send_pixel(170, 100, C_PLAYER, "player_top_edge");
        send_pixel(170, 140, C_RUN,    "player_bottom_excl");
        send_pixel(159, 115, C_OBS,    "obs_left_of_player");
        send_pixel(200, 120, C_RUN,    "right_edges_excl");

        // Mid-frame obstacle change has no effect until the next frame_start.
        set_slot(0, 400, 450, 110, 130);
        send_pixel(170, 115, C_COLL, "midframe_old_obs");
        send_pixel(420, 120, C_RUN,  "midframe_new_hidden");
        pulse_frame();
        send_pixel(420, 120, C_OBS,    "newframe_obs");
        send_pixel(170, 115, C_PLAYER, "newframe_player");

        // Player near the bottom must not wrap; degenerate slot never drawn.
        player_y = 9'd500;
        set_slot(0, 50, 50, 50, 50);
        pulse_frame();
        send_pixel(170, 5,   C_RUN,    "no_wrap");
        send_pixel(170, 505, C_PLAYER, "player_low");
        send_pixel(50, 50,   C_RUN,    "degenerate_slot");

        // Game over colours.
        gamemode = 2'b11;
        player_y = 9'd100;
        set_slot(0, 300, 340, 100, 150);
        pulse_frame();
        send_pixel(320, 120, C_OBS_OVER, "over_obs");
        send_pixel(10, 10,   C_OVER,     "over_bg");
        send_pixel(170, 120, C_PLAYER,   "over_player");

        // Pause blinking over six frames.
        gamemode = 2'b10;
        set_slot(0, 0, 0, 0, 0);
        for (int f = 0; f < 6; f++) begin
            pulse_frame();
            send_pixel(170, 110, m_blink ? C_PLAYER : C_PAUSE, $sformatf("pause_f%0d", f));
        end

        // frame_start together with a valid pixel: pixel uses the old snapshot.
        gamemode = 2'b01;
        @(negedge clk);
        pix_x       = 10'd10;
        pix_y       = 9'd10;
        pix_valid   = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        if (m_cnt == BF - 1) begin
            m_cnt   = 0;
            m_blink = ~m_blink;
        end else begin
            m_cnt++;
        end
        @(negedge clk);
        check("coincide_old", rgb, C_PAUSE);
        send_pixel(10, 10, C_RUN, "coincide_new");

        // Asynchronous reset while a pixel is in flight.
        player_y = 9'd0;
        @(negedge clk);
        pix_x     = 10'd10;
        pix_y     = 9'd10;
        pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        @(posedge clk);
        #2;
        check("rst_pre_vld", {7'd0, rgb_valid}, 8'd1);
        check("rst_pre_rgb", rgb, C_RUN);
        rst_n = 1'b0;
        #1;
        check("rst_async_rgb", rgb, 8'd0);
        check("rst_async_vld", {7'd0, rgb_valid}, 8'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_cnt   = 0;
        m_blink = 1'b0;
        send_pixel(10, 10,  C_INIT, "post_rst_bg");
        send_pixel(170, 10, C_INIT, "post_rst_no_player");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_render_pipe.md
VGA_RENDER_PIPE -- requirements
Module: vga_render_pipe

Interface
REQ-001 SHALL have parameter N_OBS, default 10, number of obstacle slots.
REQ-002 SHALL have parameter XW, default 10, pixel X coordinate width.
REQ-003 SHALL have parameter YW, default 9, pixel Y coordinate width.
REQ-004 SHALL have parameter PLAYER_X, default 160, player left edge.
REQ-005 SHALL have parameter PLAYER_SIZE, default 40, player square side.
REQ-006 SHALL have parameter BLINK_FRAMES, default 30, frames per blink half-period.
REQ-007 SHALL have port clk  input  1  pixel clock, single clock domain.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port pix_x  input  XW  current pixel X.
REQ-010 SHALL have port pix_y  input  YW  current pixel Y.
REQ-011 SHALL have port pix_valid  input  1  pix_x/pix_y inside active area.
REQ-012 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-013 SHALL have port gamemode  input  2  00 init, 01 run, 10 pause, 11 over.
REQ-014 SHALL have port player_y  input  YW  player top edge.
REQ-015 SHALL have port obstacle_x  input  N_OBS*2*XW  slot i: left at [i*2XW +: XW], right at [i*2XW+XW +: XW].
REQ-016 SHALL have port obstacle_y  input  N_OBS*2*YW  slot i: top at [i*2YW +: YW], bottom at [i*2YW+YW +: YW].
REQ-017 SHALL have port rgb  output  8  registered colour, R[7:5] G[4:2] B[1:0].
REQ-018 SHALL have port rgb_valid  output  1  rgb corresponds to a valid pixel.

Function
REQ-019 SHALL latch gamemode, player_y, obstacle_x, obstacle_y into shadow registers only in a cycle with frame_start=1; rendering uses shadow values only, so mid-frame input changes take effect next frame.
REQ-020 SHALL be a 2-stage pipeline: stage 1 registers player/obstacle/collision flags plus pix_valid; stage 2 registers rgb and rgb_valid; latency exactly 2 cycles, throughput one pixel per cycle.
REQ-021 SHALL treat slot i as disabled when left==right and top==bottom; otherwise hit when left<=x<right and top<=y<bottom (left>=right or top>=bottom yields no hit).
REQ-022 SHALL compute player hit as PLAYER_X<=x<PLAYER_X+PLAYER_SIZE and player_y<=y<player_y+PLAYER_SIZE using YW+1-bit sums (no wrap at bottom edge).
REQ-023 SHALL background colour by shadow gamemode: 00 110_110_11, 01 000_111_00, 10 111_111_00, 11 111_000_00.
REQ-024 SHALL priority: collision (player and any obstacle) 111_111_11 > player 000_000_11 > obstacle 111_011_00 > background.
REQ-025 SHALL keep a frame counter 0..BLINK_FRAMES-1, incremented on frame_start, wrapping to 0 and toggling blink_phase at BLINK_FRAMES-1.
REQ-026 SHALL in pause mode (10) suppress player and collision colours when blink_phase=0; other modes ignore blink_phase.
REQ-027 SHALL in over mode (11) draw obstacles 011_000_00 instead of 111_011_00.
REQ-028 SHALL output rgb=0 when delayed pix_valid=0; rgb_valid equals pix_valid delayed 2 cycles.
REQ-029 SHALL latch shadow registers and advance the blink counter in the same cycle when frame_start coincides with pix_valid=1.

Reset
REQ-030 SHALL on rst_n=0 asynchronously clear rgb, rgb_valid, pipeline flags, frame counter, blink_phase; shadow gamemode=00, player_y=0, all obstacle coordinates=0 (all slots disabled).
REQ-031 SHALL, after reset release mid-frame, draw init background with no objects until the first frame_start.

Structure
REQ-032 SHALL take colour constants and gamemode encodings from shared package vga_pkg.
REQ-033 SHALL implement per-slot compare in sub-module vga_obs_hit (params XW, YW), instantiated N_OBS times, outputs OR-reduced.

Verification
REQ-034 SHALL verify: shadow slot0 = x 300..340, y 100..150, mode 01; pixel (320,120) valid -> rgb=111_011_00, rgb_valid two cycles later.
REQ-035 SHALL verify: player_y=100 latched, slot0 x 150..200 y 110..130; pixel (170,115) -> 111_111_11; pixel (170,135) -> 000_000_11.
REQ-036 SHALL verify: mode 10, BLINK_FRAMES=2; pixel (170,110) player -> blue for 2 frames, 111_111_00 for next 2, repeating.
REQ-037 SHALL verify: change obstacle_x mid-frame without frame_start -> rgb unchanged; after frame_start new obstacle drawn.
REQ-038 SHALL verify: player_y=500 (YW=9) -> no wrap; pixel (170,5) background; slot with left=right=top=bottom=50 -> never drawn.
REQ-039 SHALL verify: assert rst_n=0 mid-line -> rgb=0, rgb_valid=0 immediately; after release, background 110_110_11 until frame_start.
